// File: rtl/fp_mul_pkg.sv
// Shared types and width helpers for the sequential floating-point multiplier.
// Default widths describe IEEE-754 single precision.
package fp_mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      NORM,
      DONE
   } state_t;

   localparam int EXP_WIDTH_DEF  = 8;
   localparam int MANT_WIDTH_DEF = 23;
   localparam int BIAS_DEF       = 127;

   function automatic int prod_width(input int mant_width);
      return 2 * mant_width + 2;
   endfunction

   function automatic int cnt_width(input int mant_width);
      return $clog2(mant_width + 1);
   endfunction

   localparam int PROD_WIDTH_DEF = prod_width(MANT_WIDTH_DEF);
   localparam int CNT_WIDTH_DEF  = cnt_width(MANT_WIDTH_DEF);

endpackage

// File: rtl/fp_mul_norm.sv
// Combinational normalisation of the raw mantissa product.
// Selects the mantissa window and bumps the exponent when the product carries into its MSB.
module fp_mul_norm
   import fp_mul_pkg::*;
#(
   parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int MANT_WIDTH = MANT_WIDTH_DEF,
   parameter int PW         = prod_width(MANT_WIDTH),
   parameter int EW         = EXP_WIDTH + 2
) (
   input  logic signed [EW-1:0]         exp_in,
   input  logic        [PW-1:0]         prod,
   output logic signed [EW-1:0]         exp_out,
   output logic        [MANT_WIDTH-1:0] mant_out
);

   // The product of two [1,2) mantissas lies in [1,4); the MSB marks the [2,4) case.
   always_comb begin
      exp_out  = exp_in;
      mant_out = prod[PW-3 -: MANT_WIDTH];
      if (prod[PW-1]) begin
         exp_out  = exp_in + EW'(1);
         mant_out = prod[PW-2 -: MANT_WIDTH];
      end
   end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: shift-and-add mantissa product over MANT_WIDTH+1 cycles,
// then normalise, range-check and present the packed result on a valid/ack port.
module fp_mul_seq
   import fp_mul_pkg::*;
#(
   parameter int EXP_WIDTH  = EXP_WIDTH_DEF,
   parameter int MANT_WIDTH = MANT_WIDTH_DEF,
   parameter int BIAS       = BIAS_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_Valid,
   output logic                              out_Ready,
   input  logic [EXP_WIDTH+MANT_WIDTH:0]     in_A,
   input  logic [EXP_WIDTH+MANT_WIDTH:0]     in_B,
   output logic                              out_Valid,
   input  logic                              in_Ack,
   output logic [EXP_WIDTH+MANT_WIDTH:0]     out_Result,
   output logic                              out_Ovf,
   output logic                              out_Unf
);

   localparam int W   = EXP_WIDTH + MANT_WIDTH + 1;
   localparam int EW  = EXP_WIDTH + 2;
   localparam int PW  = prod_width(MANT_WIDTH);
   localparam int CW  = cnt_width(MANT_WIDTH);
   localparam int MW1 = MANT_WIDTH + 1;
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_WIDTH) - 1);
   localparam logic        [CW-1:0] CNT_LAST = CW'(MANT_WIDTH);

   state_t state, next_state;

   logic        [CW-1:0]         cnt;
   logic        [PW-1:0]         prod;
   logic        [MW1-1:0]        mcand;
   logic        [MW1-1:0]        mplier;
   logic signed [EW-1:0]         exp_sum;
   logic                         sign;
   logic                         inf_in;

   logic        [EXP_WIDTH-1:0]  a_exp, b_exp;
   logic                         capture, zero_in;
   logic signed [EW-1:0]         norm_exp;
   logic        [MANT_WIDTH-1:0] norm_mant;

   assign a_exp     = in_A[W-2 -: EXP_WIDTH];
   assign b_exp     = in_B[W-2 -: EXP_WIDTH];
   assign capture   = in_Valid && (state == IDLE);
   assign zero_in   = (a_exp == '0) || (b_exp == '0);
   assign out_Ready = (state == IDLE);
   assign out_Valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (capture) next_state = zero_in ? DONE : MULT;
         MULT:    if (cnt == CNT_LAST) next_state = NORM;
         NORM:    next_state = DONE;
         DONE:    if (in_Ack) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   fp_mul_norm #(
      .EXP_WIDTH  (EXP_WIDTH),
      .MANT_WIDTH (MANT_WIDTH),
      .PW         (PW),
      .EW         (EW)
   ) u_norm (
      .exp_in   (exp_sum),
      .prod     (prod),
      .exp_out  (norm_exp),
      .mant_out (norm_mant)
   );

   // Denormals flush to zero, so a zero exponent field skips the multiply entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         prod       <= '0;
         mcand      <= '0;
         mplier     <= '0;
         exp_sum    <= '0;
         sign       <= 1'b0;
         inf_in     <= 1'b0;
         out_Result <= '0;
         out_Ovf    <= 1'b0;
         out_Unf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  sign    <= in_A[W-1] ^ in_B[W-1];
                  exp_sum <= EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
                  inf_in  <= (&a_exp) || (&b_exp);
                  mcand   <= {1'b1, in_A[MANT_WIDTH-1:0]};
                  mplier  <= {1'b1, in_B[MANT_WIDTH-1:0]};
                  prod    <= '0;
                  cnt     <= '0;
                  if (zero_in) begin
                     out_Result <= {in_A[W-1] ^ in_B[W-1], {(W-1){1'b0}}};
                     out_Ovf    <= 1'b0;
                     out_Unf    <= 1'b0;
                  end
               end
            end
            MULT: begin
               if (mplier[0]) prod <= prod + (PW'(mcand) << cnt);
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            NORM: begin
               out_Ovf <= 1'b0;
               out_Unf <= 1'b0;
               if (inf_in || (norm_exp >= EXP_MAX)) begin
                  out_Result <= {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                  out_Ovf    <= 1'b1;
               end else if (norm_exp[EW-1] || (norm_exp == '0)) begin
                  out_Result <= {sign, {(W-1){1'b0}}};
                  out_Unf    <= 1'b1;
               end else begin
                  out_Result <= {sign, norm_exp[EXP_WIDTH-1:0], norm_mant};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
